rtc_bus_ctrl: RTL and testbench

- Parametrised controller for the multiplexed address/data RTC bus (signals ad_n, cs_n, wr_n, rd_n).
- Each transaction is an address-write phase followed by a data phase; the data phase is a write or a read, selected per transaction.
- Phase timings are parameters, not hard-coded counter values.
- Sits between the clock/calendar sequencer (start/done handshake) and the RTC pins.

---
 rtl/rtc_bus_pkg.sv | 46 ++++
 rtl/rtc_phase_timer.sv | 28 ++
 rtl/rtc_bus_ctrl.sv | 166 ++++++++++++++++
 tb/tb_rtc_bus_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared state encoding, default phase timings and transfer
// direction encodings for the RTC multiplexed address/data bus controller.
package rtc_bus_pkg;

    typedef enum logic [3:0] {
        IDLE,
        A_AD,
        A_CS,
        A_STB,
        A_REL,
        A_END,
        GAP,
        D_CS,
        D_STB,
        D_REL,
        D_END
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 9;
    localparam int DEF_T_SU   = 10;
    localparam int DEF_T_WR   = 40;
    localparam int DEF_T_RD   = 40;
    localparam int DEF_T_HOLD = 10;
    localparam int DEF_T_GAP  = 20;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // Fixed phase order; D_END wraps back to IDLE.
    function automatic state_t next_phase(input state_t s);
        case (s)
            A_AD:    return A_CS;
            A_CS:    return A_STB;
            A_STB:   return A_REL;
            A_REL:   return A_END;
            A_END:   return GAP;
            GAP:     return D_CS;
            D_CS:    return D_STB;
            D_STB:   return D_REL;
            D_REL:   return D_END;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer: clearable dwell counter for one bus phase.
// Ports: clk, reset (async, active-high); clr restarts the count at 0 on the
// next edge; limit is the phase length in cycles; expire is high on the last
// cycle of the phase (count == limit-1).
module rtc_phase_timer #(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clr ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expire = (cnt_q == limit - 1'b1);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: sequencer for the multiplexed address/data RTC bus. Each
// transaction is an address write phase, an idle gap, then a write or read
// data phase, with every phase length set by a parameter.
// Ports: clk, reset (async, active-high); start/rw/addr/wdata request from the
// sequencer, busy/done/rdata back to it; ad_n/cs_n/wr_n/rd_n active-low RTC
// strobes; bus_out/bus_oe drive the shared bus, bus_in reads it back.
// Build option: RTC_RD_SYNC_EN adds a 2-flop synchroniser on bus_in ahead of
// read capture.
module rtc_bus_ctrl
    import rtc_bus_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int T_SU   = DEF_T_SU,
    parameter int T_WR   = DEF_T_WR,
    parameter int T_RD   = DEF_T_RD,
    parameter int T_HOLD = DEF_T_HOLD,
    parameter int T_GAP  = DEF_T_GAP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rw,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              ad_n,
    output logic              cs_n,
    output logic              wr_n,
    output logic              rd_n,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic [DATA_W-1:0] bus_in
);

    localparam int T_MAX = 2 ** CNT_W - 1;

    if (T_SU < 1 || T_SU > T_MAX || T_WR < 1 || T_WR > T_MAX ||
        T_RD < 1 || T_RD > T_MAX || T_HOLD < 1 || T_HOLD > T_MAX ||
        T_GAP < 1 || T_GAP > T_MAX) begin : g_bad_timing
        $error("rtc_bus_ctrl: every T_* must lie in 1..2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] L_SU   = CNT_W'(T_SU);
    localparam logic [CNT_W-1:0] L_WR   = CNT_W'(T_WR);
    localparam logic [CNT_W-1:0] L_RD   = CNT_W'(T_RD);
    localparam logic [CNT_W-1:0] L_HOLD = CNT_W'(T_HOLD);
    localparam logic [CNT_W-1:0] L_GAP  = CNT_W'(T_GAP);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic              rw_q, rw_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ad_n_q, ad_n_d, cs_n_q, cs_n_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
    logic [DATA_W-1:0] bus_out_q, bus_out_d;
    logic              bus_oe_q, bus_oe_d;
    logic [CNT_W-1:0]  limit;
    logic              expire, clr, accept, a_ph, d_ph, wr_dir;
    logic [DATA_W-1:0] cap;

`ifdef RTC_RD_SYNC_EN
    if (T_RD < 3) begin : g_bad_rd
        $error("rtc_bus_ctrl: T_RD must be >= 3 with the read synchroniser");
    end

    logic [DATA_W-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus_in;
            sync2_q <= sync1_q;
        end
    end

    assign cap = sync2_q;
`else
    assign cap = bus_in;
`endif

    rtc_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .limit  (limit),
        .expire (expire)
    );

    always_comb begin
        limit   = (state_q inside {A_AD, A_CS, D_CS})          ? L_SU :
                  (state_q == A_STB)                           ? L_WR :
                  (state_q == D_STB)                           ? ((rw_q == RW_READ) ? L_RD : L_WR) :
                  (state_q inside {A_REL, A_END, D_REL, D_END}) ? L_HOLD :
                  (state_q == GAP)                             ? L_GAP : L_SU;
        accept  = (state_q == IDLE) && start;
        state_d = accept                          ? A_AD :
                  (state_q != IDLE && expire)     ? next_phase(state_q) : state_q;
        clr     = (state_d != state_q);
        addr_d  = accept ? addr  : addr_q;
        wdata_d = accept ? wdata : wdata_q;
        rw_d    = accept ? rw    : rw_q;
        // Pin values are decoded from the next state so they flip on the
        // same edge as the state register and leave the block registered.
        wr_dir    = (rw_d == RW_WRITE);
        a_ph      = state_d inside {A_AD, A_CS, A_STB, A_REL, A_END};
        d_ph      = state_d inside {GAP, D_CS, D_STB, D_REL, D_END};
        ad_n_d    = !(state_d inside {A_AD, A_CS, A_STB, A_REL});
        cs_n_d    = !(state_d inside {A_CS, A_STB, A_REL, D_CS, D_STB, D_REL});
        wr_n_d    = !(state_d == A_STB || (state_d == D_STB && wr_dir));
        rd_n_d    = !(state_d == D_STB && !wr_dir);
        bus_oe_d  = a_ph || (d_ph && wr_dir);
        bus_out_d = a_ph ? addr_d : (d_ph && wr_dir) ? wdata_d : '0;
        busy_d    = (state_d != IDLE);
        done_d    = (state_q == D_END) && (state_d == IDLE);
        // Capture on the edge that ends D_STB, i.e. where rd_n returns high.
        rdata_d   = (state_q == D_STB && expire && rw_q == RW_READ) ? cap : rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rw_q      <= RW_WRITE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
            ad_n_q    <= 1'b1;
            cs_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            bus_out_q <= '0;
            bus_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            ad_n_q    <= ad_n_d;
            cs_n_q    <= cs_n_d;
            wr_n_q    <= wr_n_d;
            rd_n_q    <= rd_n_d;
            bus_out_q <= bus_out_d;
            bus_oe_q  <= bus_oe_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign ad_n    = ad_n_q;
    assign cs_n    = cs_n_q;
    assign wr_n    = wr_n_q;
    assign rd_n    = rd_n_q;
    assign bus_out = bus_out_q;
    assign bus_oe  = bus_oe_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: scoreboard bench for rtc_bus_ctrl with default timings and a
// second instance with minimal (1-cycle) phase timings.
module tb_rtc_bus_ctrl;

`ifdef RTC_RD_SYNC_EN
    localparam int F_TRD = 3;
`else
    localparam int F_TRD = 1;
`endif

    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       start = 0, rw = 0, busy, done, ad_n, cs_n, wr_n, rd_n, bus_oe;
    logic [7:0] addr = 0, wdata = 0, bus_in = 0, rdata, bus_out;
    logic       f_start = 0, f_rw = 0, f_busy, f_done, f_ad_n, f_cs_n, f_wr_n, f_rd_n, f_bus_oe;
    logic [7:0] f_addr = 0, f_wdata = 0, f_bus_in = 0, f_rdata, f_bus_out;

    rtc_bus_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .ad_n(ad_n), .cs_n(cs_n), .wr_n(wr_n),
        .rd_n(rd_n), .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
    );

    rtc_bus_ctrl #(.T_SU(1), .T_WR(1), .T_RD(F_TRD), .T_HOLD(1), .T_GAP(1)) dut_f (
        .clk(clk), .reset(reset), .start(f_start), .rw(f_rw), .addr(f_addr), .wdata(f_wdata),
        .busy(f_busy), .done(f_done), .rdata(f_rdata), .ad_n(f_ad_n), .cs_n(f_cs_n), .wr_n(f_wr_n),
        .rd_n(f_rd_n), .bus_out(f_bus_out), .bus_oe(f_bus_oe), .bus_in(f_bus_in)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int lat; int ad; int wr; int np; int b0; int b1; int rd; int rdchk; int rdata;
    } exp_t;

    exp_t       exp_q[$];
    logic [6:0] fq[$];
    int         frq[$];

    int acc_cyc = 0, done_cyc = -1000, last_gap = -1;
    int ad_low, wr_low, np, rd_low, rd_oe, both;
    int wb[2];

    // Main monitor: per-transaction pin statistics, checked against the
    // scoreboard entry when done appears.
    initial begin
        logic busy_p = 0, wr_p = 1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy && !busy_p) begin
                acc_cyc = cyc; last_gap = cyc - done_cyc;
                ad_low = 0; wr_low = 0; np = 0; rd_low = 0; rd_oe = 0; both = 0;
            end
            if (!ad_n) ad_low++;
            if (!wr_n) wr_low++;
            if (!rd_n) rd_low++;
            if (!rd_n && bus_oe) rd_oe++;
            if (!rd_n && !wr_n) both++;
            if (!wr_n && wr_p) begin
                if (np < 2) wb[np] = int'(bus_out);
                np++;
            end
            if (done) begin
                if (exp_q.size() == 0) chk("spurious_done", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    chk("latency", cyc - acc_cyc, e.lat);
                    chk("ad_n_low_cycles", ad_low, e.ad);
                    chk("wr_n_low_cycles", wr_low, e.wr);
                    chk("wr_n_pulses", np, e.np);
                    chk("bus_out_pulse0", wb[0], e.b0);
                    if (e.np == 2) chk("bus_out_pulse1", wb[1], e.b1);
                    chk("rd_n_low_cycles", rd_low, e.rd);
                    chk("oe_during_rd", rd_oe, 0);
                    chk("wr_rd_overlap", both, 0);
                    if (e.rdchk != 0) chk("rdata", int'(rdata), e.rdata);
                    chk("done_busy_low", int'(busy), 0);
                end
                done_cyc = cyc;
            end
            busy_p = busy; wr_p = wr_n;
        end
    end

    // Fast-instance monitor: cycle-by-cycle pin vectors {busy,done,ad,cs,wr,rd,oe}.
    initial begin
        logic [6:0] v;
        forever begin
            @(negedge clk);
            if ((f_busy || f_done) && fq.size() > 0) begin
                v = fq.pop_front();
                chk("fast_vec", int'({f_busy, f_done, f_ad_n, f_cs_n, f_wr_n, f_rd_n, f_bus_oe}), int'(v));
            end
            if (f_done && frq.size() > 0) chk("fast_rdata", int'(f_rdata), frq.pop_front());
        end
    end

    function automatic exp_t mk(input int wr, input int np, input int b0, input int b1,
                                input int rd, input int rdchk, input int rdv);
        exp_t e;
        e.lat = 170; e.ad = 70; e.wr = wr; e.np = np; e.b0 = b0; e.b1 = b1;
        e.rd = rd; e.rdchk = rdchk; e.rdata = rdv;
        return e;
    endfunction

    task automatic push_fast(input logic r);
        logic w;
        w = !r;
        fq.push_back(7'b1001111);
        fq.push_back(7'b1000111);
        fq.push_back(7'b1000011);
        fq.push_back(7'b1000111);
        fq.push_back(7'b1011111);
        fq.push_back({6'b101111, w});
        fq.push_back({6'b101011, w});
        repeat (r ? F_TRD : 1) fq.push_back({4'b1010, r, w, w});
        fq.push_back({6'b101011, w});
        fq.push_back({6'b101111, w});
        fq.push_back(7'b0111110);
    endtask

    task automatic issue(input logic r, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk); start = 1; rw = r; addr = a; wdata = d;
        @(negedge clk); start = 0;
    endtask

    task automatic issue_f(input logic r, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk); f_start = 1; f_rw = r; f_addr = a; f_wdata = d;
        @(negedge clk); f_start = 0;
    endtask

    task automatic wait_done(input string nm);
        int i = 0;
        do begin @(negedge clk); i++; end while (!done && i < 400);
        chk(nm, int'(done), 1);
    endtask

    task automatic wait_fdone(input string nm);
        int i = 0;
        do begin @(negedge clk); i++; end while (!f_done && i < 100);
        chk(nm, int'(f_done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        repeat (3) @(negedge clk);
        reset = 0;
        repeat (20) @(negedge clk);
        chk("idle_pins", int'({ad_n, cs_n, wr_n, rd_n, bus_oe}), 5'b11110);
        chk("idle_busy_done", int'({busy, done}), 0);
        chk("idle_rdata", int'(rdata), 0);
        chk("idle_bus_out", int'(bus_out), 0);
        chk("fast_idle_pins", int'({f_ad_n, f_cs_n, f_wr_n, f_rd_n, f_bus_oe, f_busy, f_done}), 7'b1111000);

        exp_q.push_back(mk(80, 2, 8'h21, 8'h5A, 0, 0, 0));
        issue(0, 8'h21, 8'h5A);
        wait_done("wr_done");

        exp_q.push_back(mk(40, 1, 8'h43, 0, 40, 1, 8'hC7));
        bus_in = 8'h00;
        issue(1, 8'h43, 8'h00);
        i = 0;
        while (rd_n && i < 300) begin @(negedge clk); i++; end
        chk("rd_n_asserted", int'(rd_n), 0);
        bus_in = 8'hC7;
        wait_done("rd_done");
        bus_in = 8'h00;

        exp_q.push_back(mk(80, 2, 8'h11, 8'h22, 0, 0, 0));
        issue(0, 8'h11, 8'h22);
        repeat (50) @(negedge clk);
        start = 1; rw = 1; addr = 8'h99; wdata = 8'h77;
        @(negedge clk); start = 0;
        wait_done("busy_start_done");
        repeat (5) @(negedge clk);
        chk("no_retrigger", int'(busy), 0);

        exp_q.push_back(mk(80, 2, 8'h55, 8'h66, 0, 0, 0));
        exp_q.push_back(mk(80, 2, 8'h55, 8'h66, 0, 0, 0));
        @(negedge clk); start = 1; rw = 0; addr = 8'h55; wdata = 8'h66;
        wait_done("b2b_done1");
        @(negedge clk); start = 0;
        chk("b2b_restart_busy", int'(busy), 1);
        wait_done("b2b_done2");
        chk("b2b_gap", last_gap, 1);

        issue(0, 8'h33, 8'h44);
        i = 0;
        while (wr_n && i < 100) begin @(negedge clk); i++; end
        chk("a_stb_reached", int'(wr_n), 0);
        repeat (5) @(negedge clk);
        #2 reset = 1;
        #1;
        chk("async_reset_pins", int'({ad_n, cs_n, wr_n, rd_n, bus_oe, busy, done}), 7'b1111000);
        chk("async_reset_bus_out", int'(bus_out), 0);
        chk("async_reset_rdata", int'(rdata), 0);
        @(negedge clk); reset = 0;

        exp_q.push_back(mk(80, 2, 8'h5C, 8'hA5, 0, 0, 0));
        issue(0, 8'h5C, 8'hA5);
        wait_done("post_reset_done");

        push_fast(0);
        issue_f(0, 8'h0A, 8'hB0);
        wait_fdone("fast_wr_done");

        push_fast(1);
        f_bus_in = 8'h0F;
        issue_f(1, 8'h0C, 8'h00);
        i = 0;
        while (f_rd_n && i < 50) begin @(negedge clk); i++; end
        chk("fast_rd_n_asserted", int'(f_rd_n), 0);
`ifdef RTC_RD_SYNC_EN
        @(negedge clk);
        f_bus_in = 8'hF0;
        frq.push_back(8'h0F);
`else
        f_bus_in = 8'hF0;
        frq.push_back(8'hF0);
`endif
        wait_fdone("fast_rd_done");

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size() + fq.size() + frq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
